execute_unit: RTL and testbench
===============================

EXECUTE_UNIT -- requirements
Module: execute_unit

Interface
REQ-001 SHALL have port clk, input, 1, single pipeline clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, synchronous active-low reset sampled on rising clk.
REQ-003 SHALL have inputs RD1E, RD2E, PCE, ImmExtE, PCPlus4E (32 each): operand, PC and immediate values from decode/execute register.
REQ-004 SHALL have inputs ALUControlE (4), ALUSrcE (1), ALUSrcASelE (1; 1 selects PCE as operand A), JumpE (1), BranchE (1), Funct3E (3; branch condition).
REQ-005 SHALL have inputs MulDivE (1; M-extension op present), MulDivOpE (3; funct3 encoding MUL..REMU).
REQ-006 SHALL have inputs ForwardAE, ForwardBE (2 each: 00 register, 01 ResultW, 10 ALUResultM), ALUResultM (32), ResultW (32).
REQ-007 SHALL have outputs ALUResultE (32), WriteDataE (32; forwarded B before immediate mux), PCTargetE (32), PCSrcE (1).
REQ-008 SHALL have output MulDivBusyE (1): stall request to hazard unit, which asserts stallE and stalls F/D while high.

Function
REQ-009 SHALL select SrcA = PCE when ALUSrcASelE=1, else the forwarded RD1 value; SrcB = ImmExtE when ALUSrcE=1, else forwarded RD2.
REQ-010 SHALL implement ALU ops ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, LUI-pass-B in one combinational cycle; shifts use SrcB[4:0].
REQ-011 SHALL compute PCTargetE = PCE + ImmExtE; JALR target (ALUSrcASelE=0, JumpE=1) = (SrcA + ImmExtE) & ~1.
REQ-012 SHALL assert PCSrcE = JumpE | (BranchE & cond(Funct3E)); cond covers BEQ, BNE, BLT, BGE, BLTU, BGEU; reserved Funct3E gives cond=0.
REQ-013 SHALL run a mul/div FSM with states IDLE, MUL, DIV, DONE.
REQ-014 IDLE with MulDivE=1: MulDivBusyE SHALL assert combinationally the same cycle; operands latched at that edge; next state MUL (MUL/MULH/MULHSU/MULHU) or DIV.
REQ-015 MUL SHALL last exactly 1 cycle (registered 64-bit product) then go to DONE; total latency 2 cycles stalled.
REQ-016 DIV SHALL be radix-2 restoring, 32 iterations, then DONE; total 33 cycles stalled.
REQ-017 DONE SHALL deassert MulDivBusyE and drive ALUResultE with the latched result; next edge returns to IDLE whatever MulDivE is, since the instruction advances.
REQ-018 Divide by zero SHALL give quotient 0xFFFFFFFF and remainder = dividend; signed 0x80000000 / -1 SHALL give quotient 0x80000000, remainder 0.
REQ-019 Signed division SHALL operate on magnitudes; quotient sign = XOR of operand signs; remainder sign = dividend sign.
REQ-020 Mul/div operands SHALL be sampled after forwarding in IDLE only; later changes on ForwardAE/BE are ignored.
REQ-021 While MulDivE=0, the FSM SHALL stay IDLE and MulDivBusyE SHALL be 0.

Reset
REQ-022 rst_n=0 SHALL force IDLE, clear iteration counter, latched operands and result, and drive MulDivBusyE=0 the following cycle, including mid-divide.
REQ-023 Combinational outputs SHALL need no reset; with all inputs zero, ALUResultE=0 and PCSrcE=0.

Configuration
REQ-024 Macro RV32M_DIV_EN defined: DIV, DIVU, REM, REMU SHALL be implemented per REQ-016..019.
REQ-025 Macro undefined: divider logic SHALL be absent; div ops return 0 with no busy cycles; MUL ops unchanged.

Structure
REQ-026 A shared package riscv_pkg SHALL hold the ALUControl encodings, MulDivOp encodings, Forward select encodings and FSM state typedef.
REQ-027 The iterative divider SHALL be one sub-module, muldiv_divider (start, operands, signed flag, busy, done, quotient, remainder).

Verification
REQ-028 ADD with ForwardAE=10, ALUResultM=5, RD2E=7 -> ALUResultE=12 in the same cycle.
REQ-029 BLT with SrcA=0xFFFFFFFF, SrcB=1, BranchE=1 -> PCSrcE=1; same with BLTU -> PCSrcE=0.
REQ-030 MULHU 0xFFFFFFFF*0xFFFFFFFF -> busy 2 cycles, DONE ALUResultE=0xFFFFFFFE.
REQ-031 DIV -7/2 -> busy 33 cycles, quotient 0xFFFFFFFD; REM -> 0xFFFFFFFF.
REQ-032 DIVU 5/0 -> 0xFFFFFFFF; DIV 0x80000000/-1 -> 0x80000000; REM of the same -> 0.
REQ-033 rst_n low at cycle 10 of a DIV -> next cycle IDLE, MulDivBusyE=0; new MUL then completes normally.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 execute-stage encodings: ALU controls, M-extension ops,
// forwarding selects, divider iteration bound and the mul/div sequencer state.
package riscv_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_LUI  = 4'b1010;

  // funct3 encodings of the M extension; bit 2 separates divide from multiply
  localparam logic [2:0] MD_OP_MUL    = 3'b000;
  localparam logic [2:0] MD_OP_MULH   = 3'b001;
  localparam logic [2:0] MD_OP_MULHSU = 3'b010;
  localparam logic [2:0] MD_OP_MULHU  = 3'b011;
  localparam logic [2:0] MD_OP_DIV    = 3'b100;
  localparam logic [2:0] MD_OP_DIVU   = 3'b101;
  localparam logic [2:0] MD_OP_REM    = 3'b110;
  localparam logic [2:0] MD_OP_REMU   = 3'b111;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [4:0] DIV_LAST_ITER = 5'd31;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_MUL  = 2'b01,
    MD_DIV  = 2'b10,
    MD_DONE = 2'b11
  } mdState_e;

endpackage

// File: rtl/execute_unit_if.sv
// Operand, control and result bundle between the decode/execute register,
// the forwarding network and the execute stage.
interface execute_unit_if;
  logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
  logic [3:0]  ALUControlE;
  logic        ALUSrcE, ALUSrcASelE, JumpE, BranchE;
  logic [2:0]  Funct3E;
  logic        MulDivE;
  logic [2:0]  MulDivOpE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ALUResultM, ResultW;
  logic [31:0] ALUResultE, WriteDataE, PCTargetE;
  logic        PCSrcE, MulDivBusyE;

  modport master (
    output RD1E, RD2E, PCE, ImmExtE, PCPlus4E, ALUControlE, ALUSrcE, ALUSrcASelE,
           JumpE, BranchE, Funct3E, MulDivE, MulDivOpE, ForwardAE, ForwardBE,
           ALUResultM, ResultW,
    input  ALUResultE, WriteDataE, PCTargetE, PCSrcE, MulDivBusyE
  );

  modport slave (
    input  RD1E, RD2E, PCE, ImmExtE, PCPlus4E, ALUControlE, ALUSrcE, ALUSrcASelE,
           JumpE, BranchE, Funct3E, MulDivE, MulDivOpE, ForwardAE, ForwardBE,
           ALUResultM, ResultW,
    output ALUResultE, WriteDataE, PCTargetE, PCSrcE, MulDivBusyE
  );
endinterface

// File: rtl/muldiv_divider.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle
// over 32 cycles on operand magnitudes, with sign and divide-by-zero fixups.
module muldiv_divider
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);
  logic        busy_q, negQ_q, negR_q, divZero_q;
  logic [4:0]  count_q;
  logic [31:0] quo_q, quo_d, rem_q, rem_d, divisor_q, dividend_q;
  logic [31:0] absDividend, absDivisor;
  logic [32:0] remShift, diff;

  assign absDividend = (signed_i && dividend_i[31]) ? -dividend_i : dividend_i;
  assign absDivisor  = (signed_i && divisor_i[31])  ? -divisor_i  : divisor_i;

  // Shift the next dividend bit into the partial remainder; keep the subtraction only if it does not go negative.
  always_comb begin
    remShift = {rem_q, quo_q[31]};
    diff     = remShift - {1'b0, divisor_q};
    if (diff[32]) begin
      rem_d = remShift[31:0];
      quo_d = {quo_q[30:0], 1'b0};
    end else begin
      rem_d = diff[31:0];
      quo_d = {quo_q[30:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q     <= 1'b0;
      count_q    <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      divisor_q  <= '0;
      dividend_q <= '0;
      negQ_q     <= 1'b0;
      negR_q     <= 1'b0;
      divZero_q  <= 1'b0;
    end else if (start_i) begin
      busy_q     <= 1'b1;
      count_q    <= '0;
      quo_q      <= absDividend;
      rem_q      <= '0;
      divisor_q  <= absDivisor;
      dividend_q <= dividend_i;
      negQ_q     <= signed_i && (dividend_i[31] ^ divisor_i[31]);
      negR_q     <= signed_i && dividend_i[31];
      divZero_q  <= (divisor_i == 32'd0);
    end else if (busy_q) begin
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      count_q <= count_q + 5'd1;
      if (count_q == DIV_LAST_ITER) busy_q <= 1'b0;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = busy_q && (count_q == DIV_LAST_ITER);
  assign quotient_o  = divZero_q ? 32'hFFFF_FFFF : (negQ_q ? -quo_q : quo_q);
  assign remainder_o = divZero_q ? dividend_q : (negR_q ? -rem_q : rem_q);

endmodule

// File: rtl/execute_unit.sv
// RV32IM execute stage: forwarding muxes, ALU, branch/jump resolution and a
// mul/div sequencer. Define RV32M_DIV_EN to build the iterative divider.
module execute_unit
  import riscv_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  execute_unit_if.slave ex
);
  logic [31:0] fwdA, fwdB, srcA, srcB, aluResult, mdResult;
  logic [31:0] opA_q, opB_q, divQuot, divRem;
  logic [63:0] prod_q, prod_d;
  logic [2:0]  op_q;
  logic        branchCond, mdBusy, mdLatch, aSigned, bSigned, divBusy, divDone;
  mdState_e    state_q, state_d;

  always_comb begin
    case (ex.ForwardAE)
      FWD_WB:  fwdA = ex.ResultW;
      FWD_MEM: fwdA = ex.ALUResultM;
      default: fwdA = ex.RD1E;
    endcase
    case (ex.ForwardBE)
      FWD_WB:  fwdB = ex.ResultW;
      FWD_MEM: fwdB = ex.ALUResultM;
      default: fwdB = ex.RD2E;
    endcase
  end

  assign srcA          = ex.ALUSrcASelE ? ex.PCE : fwdA;
  assign srcB          = ex.ALUSrcE ? ex.ImmExtE : fwdB;
  assign ex.WriteDataE = fwdB;

  always_comb begin
    case (ex.ALUControlE)
      ALU_ADD:  aluResult = srcA + srcB;
      ALU_SUB:  aluResult = srcA - srcB;
      ALU_AND:  aluResult = srcA & srcB;
      ALU_OR:   aluResult = srcA | srcB;
      ALU_XOR:  aluResult = srcA ^ srcB;
      ALU_SLL:  aluResult = srcA << srcB[4:0];
      ALU_SRL:  aluResult = srcA >> srcB[4:0];
      ALU_SRA:  aluResult = $unsigned($signed(srcA) >>> srcB[4:0]);
      ALU_SLT:  aluResult = {31'd0, $signed(srcA) < $signed(srcB)};
      ALU_SLTU: aluResult = {31'd0, srcA < srcB};
      ALU_LUI:  aluResult = srcB;
      default:  aluResult = '0;
    endcase
  end

  always_comb begin
    case (ex.Funct3E)
      3'b000:  branchCond = (srcA == srcB);
      3'b001:  branchCond = (srcA != srcB);
      3'b100:  branchCond = ($signed(srcA) < $signed(srcB));
      3'b101:  branchCond = ($signed(srcA) >= $signed(srcB));
      3'b110:  branchCond = (srcA < srcB);
      3'b111:  branchCond = (srcA >= srcB);
      default: branchCond = 1'b0;
    endcase
  end

  // JALR adds the immediate to the register operand and clears bit 0; JAL and branches are PC-relative.
  assign ex.PCTargetE = (ex.JumpE && !ex.ALUSrcASelE) ? ((fwdA + ex.ImmExtE) & ~32'd1)
                                                      : (ex.PCE + ex.ImmExtE);
  assign ex.PCSrcE    = ex.JumpE | (ex.BranchE & branchCond);

`ifdef RV32M_DIV_EN
  localparam bit DivEnable = 1'b1;
  logic divStart;
  assign divStart = (state_q == MD_IDLE) && ex.MulDivE && ex.MulDivOpE[2];

  muldiv_divider u_divider (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (divStart),
    .signed_i    (!ex.MulDivOpE[0]),
    .dividend_i  (fwdA),
    .divisor_i   (fwdB),
    .busy_o      (divBusy),
    .done_o      (divDone),
    .quotient_o  (divQuot),
    .remainder_o (divRem)
  );
`else
  localparam bit DivEnable = 1'b0;
  assign divBusy = 1'b0;
  assign divDone = 1'b0;
  assign divQuot = '0;
  assign divRem  = '0;
`endif

  always_comb begin
    state_d = state_q;
    mdBusy  = 1'b0;
    mdLatch = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (ex.MulDivE && (!ex.MulDivOpE[2] || DivEnable)) begin
          mdBusy  = 1'b1;
          mdLatch = 1'b1;
          state_d = ex.MulDivOpE[2] ? MD_DIV : MD_MUL;
        end
      end
      MD_MUL: begin
        mdBusy  = 1'b1;
        state_d = MD_DONE;
      end
      MD_DIV: begin
        mdBusy = 1'b1;
        if (divDone || !divBusy) state_d = MD_DONE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // Sign-extending both operands to 64 bits lets one unsigned multiplier serve all four multiply flavours.
  assign aSigned = (op_q == MD_OP_MULH) || (op_q == MD_OP_MULHSU);
  assign bSigned = (op_q == MD_OP_MULH);
  assign prod_d  = {{32{aSigned & opA_q[31]}}, opA_q} * {{32{bSigned & opB_q[31]}}, opB_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      opA_q   <= '0;
      opB_q   <= '0;
      op_q    <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      if (mdLatch) begin
        opA_q <= fwdA;
        opB_q <= fwdB;
        op_q  <= ex.MulDivOpE;
      end
      if (state_q == MD_MUL) prod_q <= prod_d;
    end
  end

  always_comb begin
    if (op_q[2])                 mdResult = op_q[1] ? divRem : divQuot;
    else if (op_q == MD_OP_MUL)  mdResult = prod_q[31:0];
    else                         mdResult = prod_q[63:32];
  end

  assign ex.ALUResultE  = (state_q == MD_DONE) ? mdResult :
                          (!DivEnable && ex.MulDivE && ex.MulDivOpE[2]) ? 32'd0 : aluResult;
  assign ex.MulDivBusyE = mdBusy;

endmodule

// File: tb/tb_execute_unit.sv
// Directed testbench for execute_unit: ALU, forwarding, branches, mul/div
// latency and results, and reset during a divide.
module tb_execute_unit;
  import riscv_pkg::*;

`ifdef RV32M_DIV_EN
  localparam bit DivOn     = 1'b1;
  localparam int DivCycles = 33;
`else
  localparam bit DivOn     = 1'b0;
  localparam int DivCycles = 0;
`endif

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a, b, exp;
  } aluVec_t;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic        br, jp, exp;
  } brVec_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, exp;
  } mdVec_t;

  logic clk;
  logic rst_n;
  int   nCompared;
  int   nMismatched;

  execute_unit_if exIf ();

  execute_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ex    (exIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clearInputs();
    exIf.RD1E = '0; exIf.RD2E = '0; exIf.PCE = '0; exIf.ImmExtE = '0; exIf.PCPlus4E = '0;
    exIf.ALUControlE = ALU_ADD; exIf.ALUSrcE = 1'b0; exIf.ALUSrcASelE = 1'b0;
    exIf.JumpE = 1'b0; exIf.BranchE = 1'b0; exIf.Funct3E = 3'b000;
    exIf.MulDivE = 1'b0; exIf.MulDivOpE = MD_OP_MUL;
    exIf.ForwardAE = FWD_REG; exIf.ForwardBE = FWD_REG;
    exIf.ALUResultM = '0; exIf.ResultW = '0;
  endtask

  // Issues one M-extension op and counts stalled cycles; live operands are scrambled once it has started.
  task automatic runMulDiv(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic busyNow, output int cycles, output logic [31:0] result);
    @(posedge clk); #1;
    exIf.RD1E = a; exIf.RD2E = b;
    exIf.ForwardAE = FWD_REG; exIf.ForwardBE = FWD_REG;
    exIf.MulDivOpE = op; exIf.MulDivE = 1'b1;
    #1;
    busyNow = exIf.MulDivBusyE;
    cycles = 0;
    while (exIf.MulDivBusyE === 1'b1 && cycles < 100) begin
      cycles++;
      @(posedge clk); #1;
      exIf.ForwardAE = FWD_WB; exIf.ForwardBE = FWD_MEM;
      exIf.ResultW = 32'h0BAD_0001; exIf.ALUResultM = 32'h0BAD_0002;
      exIf.RD1E = 32'h1234_5678; exIf.RD2E = 32'h0000_0003;
      #1;
    end
    if (cycles >= 100) cycles = -1;
    result = exIf.ALUResultE;
    exIf.MulDivE = 1'b0;
    exIf.ForwardAE = FWD_REG; exIf.ForwardBE = FWD_REG;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clearInputs();
    repeat (2) @(posedge clk);
    #1;
    nCompared++;
    if (exIf.MulDivBusyE !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL reset_busy: got %b, expected 0", exIf.MulDivBusyE);
    end
    nCompared++;
    if (exIf.ALUResultE !== 32'd0) begin
      nMismatched++; $display("[TB] FAIL reset_alu: got %h, expected 00000000", exIf.ALUResultE);
    end
    nCompared++;
    if (exIf.PCSrcE !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL reset_pcsrc: got %b, expected 0", exIf.PCSrcE);
    end
    nCompared++;
    if (exIf.PCTargetE !== 32'd0) begin
      nMismatched++; $display("[TB] FAIL reset_pctarget: got %h, expected 00000000", exIf.PCTargetE);
    end
    rst_n = 1'b1;
    exIf.MulDivOpE = MD_OP_DIVU;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      nCompared++;
      if (exIf.MulDivBusyE !== 1'b0) begin
        nMismatched++; $display("[TB] FAIL idle_busy_%0d: got %b, expected 0", i, exIf.MulDivBusyE);
      end
    end
  endtask

  task automatic test_alu();
    aluVec_t v [10];
    clearInputs();
    v[0] = '{ALU_SUB,  32'd3,          32'd5,          32'hFFFF_FFFE};
    v[1] = '{ALU_AND,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000};
    v[2] = '{ALU_OR,   32'h0F0F_0000,  32'h0000_00F0,  32'h0F0F_00F0};
    v[3] = '{ALU_XOR,  32'hFFFF_0000,  32'h0F0F_0F0F,  32'hF0F0_0F0F};
    v[4] = '{ALU_SLL,  32'd1,          32'h0000_0021,  32'd2};
    v[5] = '{ALU_SRL,  32'h8000_0000,  32'd4,          32'h0800_0000};
    v[6] = '{ALU_SRA,  32'h8000_0000,  32'd4,          32'hF800_0000};
    v[7] = '{ALU_SLT,  32'hFFFF_FFFF,  32'd1,          32'd1};
    v[8] = '{ALU_SLTU, 32'hFFFF_FFFF,  32'd1,          32'd0};
    v[9] = '{ALU_LUI,  32'h0000_1234,  32'hABCD_E000,  32'hABCD_E000};
    for (int i = 0; i < 10; i++) begin
      exIf.ALUControlE = v[i].ctrl; exIf.RD1E = v[i].a; exIf.RD2E = v[i].b;
      #1;
      nCompared++;
      if (exIf.ALUResultE !== v[i].exp) begin
        nMismatched++;
        $display("[TB] FAIL alu_%0d: got %h, expected %h", i, exIf.ALUResultE, v[i].exp);
      end
    end
  endtask

  task automatic test_forwarding();
    clearInputs();
    exIf.ForwardAE = FWD_MEM; exIf.ALUResultM = 32'd5; exIf.RD1E = 32'd999; exIf.RD2E = 32'd7;
    #1;
    nCompared++;
    if (exIf.ALUResultE !== 32'd12) begin
      nMismatched++; $display("[TB] FAIL fwd_mem_add: got %h, expected 0000000c", exIf.ALUResultE);
    end
    exIf.ForwardAE = FWD_REG; exIf.RD1E = 32'd1; exIf.ForwardBE = FWD_WB; exIf.ResultW = 32'd100;
    #1;
    nCompared++;
    if (exIf.ALUResultE !== 32'd101) begin
      nMismatched++; $display("[TB] FAIL fwd_wb_add: got %h, expected 00000065", exIf.ALUResultE);
    end
    exIf.ALUSrcE = 1'b1; exIf.ImmExtE = 32'h10;
    #1;
    nCompared++;
    if (exIf.ALUResultE !== 32'h11) begin
      nMismatched++; $display("[TB] FAIL imm_add: got %h, expected 00000011", exIf.ALUResultE);
    end
    nCompared++;
    if (exIf.WriteDataE !== 32'd100) begin
      nMismatched++; $display("[TB] FAIL writedata: got %h, expected 00000064", exIf.WriteDataE);
    end
    exIf.ALUSrcASelE = 1'b1; exIf.PCE = 32'h1000;
    #1;
    nCompared++;
    if (exIf.ALUResultE !== 32'h1010) begin
      nMismatched++; $display("[TB] FAIL pc_add: got %h, expected 00001010", exIf.ALUResultE);
    end
  endtask

  task automatic test_branch();
    brVec_t v [9];
    clearInputs();
    v[0] = '{3'b100, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b1};
    v[1] = '{3'b110, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b0};
    v[2] = '{3'b000, 32'd5,         32'd5, 1'b1, 1'b0, 1'b1};
    v[3] = '{3'b001, 32'd5,         32'd5, 1'b1, 1'b0, 1'b0};
    v[4] = '{3'b101, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b0};
    v[5] = '{3'b111, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b1};
    v[6] = '{3'b010, 32'd5,         32'd5, 1'b1, 1'b0, 1'b0};
    v[7] = '{3'b000, 32'd5,         32'd5, 1'b0, 1'b0, 1'b0};
    v[8] = '{3'b010, 32'd5,         32'd6, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 9; i++) begin
      exIf.Funct3E = v[i].f3; exIf.RD1E = v[i].a; exIf.RD2E = v[i].b;
      exIf.BranchE = v[i].br; exIf.JumpE = v[i].jp;
      #1;
      nCompared++;
      if (exIf.PCSrcE !== v[i].exp) begin
        nMismatched++;
        $display("[TB] FAIL branch_%0d: got %b, expected %b", i, exIf.PCSrcE, v[i].exp);
      end
    end
    clearInputs();
    exIf.PCE = 32'h100; exIf.ImmExtE = 32'h20; exIf.BranchE = 1'b1;
    #1;
    nCompared++;
    if (exIf.PCTargetE !== 32'h120) begin
      nMismatched++; $display("[TB] FAIL branch_target: got %h, expected 00000120", exIf.PCTargetE);
    end
    exIf.BranchE = 1'b0; exIf.JumpE = 1'b1; exIf.RD1E = 32'h1003; exIf.ImmExtE = 32'h4;
    #1;
    nCompared++;
    if (exIf.PCTargetE !== 32'h1006) begin
      nMismatched++; $display("[TB] FAIL jalr_target: got %h, expected 00001006", exIf.PCTargetE);
    end
    exIf.ALUSrcASelE = 1'b1; exIf.PCE = 32'h2000; exIf.ImmExtE = 32'h10;
    #1;
    nCompared++;
    if (exIf.PCTargetE !== 32'h2010) begin
      nMismatched++; $display("[TB] FAIL jal_target: got %h, expected 00002010", exIf.PCTargetE);
    end
  endtask

  task automatic test_mul();
    mdVec_t      v [4];
    logic        busyNow;
    int          cycles;
    logic [31:0] result;
    clearInputs();
    v[0] = '{MD_OP_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB};
    v[1] = '{MD_OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    v[2] = '{MD_OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF};
    v[3] = '{MD_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    for (int i = 0; i < 4; i++) begin
      runMulDiv(v[i].op, v[i].a, v[i].b, busyNow, cycles, result);
      nCompared++;
      if (busyNow !== 1'b1) begin
        nMismatched++; $display("[TB] FAIL mul_%0d_busy_now: got %b, expected 1", i, busyNow);
      end
      nCompared++;
      if (cycles !== 2) begin
        nMismatched++; $display("[TB] FAIL mul_%0d_cycles: got %0d, expected 2", i, cycles);
      end
      nCompared++;
      if (result !== v[i].exp) begin
        nMismatched++; $display("[TB] FAIL mul_%0d_result: got %h, expected %h", i, result, v[i].exp);
      end
    end
  endtask

  task automatic test_div();
    mdVec_t      v [8];
    logic        busyNow;
    int          cycles;
    logic [31:0] result, expRes;
    clearInputs();
    v[0] = '{MD_OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
    v[1] = '{MD_OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
    v[2] = '{MD_OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF};
    v[3] = '{MD_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    v[4] = '{MD_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
    v[5] = '{MD_OP_REMU, 32'd100,       32'd7,         32'd2};
    v[6] = '{MD_OP_REM,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9};
    v[7] = '{MD_OP_DIVU, 32'd100,       32'd7,         32'd14};
    for (int i = 0; i < 8; i++) begin
      runMulDiv(v[i].op, v[i].a, v[i].b, busyNow, cycles, result);
      expRes = DivOn ? v[i].exp : 32'd0;
      nCompared++;
      if (busyNow !== DivOn) begin
        nMismatched++; $display("[TB] FAIL div_%0d_busy_now: got %b, expected %b", i, busyNow, DivOn);
      end
      nCompared++;
      if (cycles !== DivCycles) begin
        nMismatched++; $display("[TB] FAIL div_%0d_cycles: got %0d, expected %0d", i, cycles, DivCycles);
      end
      nCompared++;
      if (result !== expRes) begin
        nMismatched++; $display("[TB] FAIL div_%0d_result: got %h, expected %h", i, result, expRes);
      end
    end
  endtask

  task automatic test_reset_mid_div();
    logic        busyNow;
    int          cycles;
    logic [31:0] result;
    clearInputs();
    @(posedge clk); #1;
    exIf.RD1E = 32'd100; exIf.RD2E = 32'd3; exIf.MulDivOpE = MD_OP_DIVU; exIf.MulDivE = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0; exIf.MulDivE = 1'b0;
    @(posedge clk); #1;
    nCompared++;
    if (exIf.MulDivBusyE !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL midreset_busy: got %b, expected 0", exIf.MulDivBusyE);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    nCompared++;
    if (exIf.ALUResultE !== 32'd103) begin
      nMismatched++; $display("[TB] FAIL midreset_alu: got %h, expected 00000067", exIf.ALUResultE);
    end
    runMulDiv(MD_OP_MUL, 32'd6, 32'd7, busyNow, cycles, result);
    nCompared++;
    if (cycles !== 2) begin
      nMismatched++; $display("[TB] FAIL midreset_mul_cycles: got %0d, expected 2", cycles);
    end
    nCompared++;
    if (result !== 32'd42) begin
      nMismatched++; $display("[TB] FAIL midreset_mul_result: got %h, expected 0000002a", result);
    end
    runMulDiv(MD_OP_DIVU, 32'd100, 32'd3, busyNow, cycles, result);
    nCompared++;
    if (cycles !== DivCycles) begin
      nMismatched++; $display("[TB] FAIL midreset_div_cycles: got %0d, expected %0d", cycles, DivCycles);
    end
    nCompared++;
    if (result !== (DivOn ? 32'd33 : 32'd0)) begin
      nMismatched++; $display("[TB] FAIL midreset_div_result: got %h, expected %h", result,
                              (DivOn ? 32'd33 : 32'd0));
    end
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    test_reset();
    test_alu();
    test_forwarding();
    test_branch();
    test_mul();
    test_div();
    test_reset_mid_div();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
